// File: rtl/rams_dist_arb_if.sv
// rtl/rams_dist_arb_if.sv - requester, response and RAM port-A signals for rams_dist_arb
interface rams_dist_arb_if #(
    parameter int AW = 6,
    parameter int DW = 16
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_rdata;
    logic          req1_valid;
    logic          req1_ready;
    logic          req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_spo;
    logic          init_done;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  ram_spo,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output ram_we, ram_a, ram_di, init_done
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  init_done
    );

    modport mem (
        input  ram_we, ram_a, ram_di,
        output ram_spo
    );
endinterface

// File: rtl/rams_dist_arb.sv
// rtl/rams_dist_arb.sv - init clear plus round-robin two-requester front end for distributed RAM port A
module rams_dist_arb #(
    parameter int            AW       = 6,
    parameter int            DW       = 16,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    rams_dist_arb_if.slave bus
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          prio_q, prio_d;
    logic          rsp0_valid_q, rsp0_valid_d;
    logic          rsp1_valid_q, rsp1_valid_d;
    logic [DW-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DW-1:0] rsp1_rdata_q, rsp1_rdata_d;
    logic          grant0, grant1;
    logic          ram_we_c;
    logic [AW-1:0] ram_a_c;
    logic [DW-1:0] ram_di_c;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prio_d       = prio_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        grant0       = 1'b0;
        grant1       = 1'b0;
        ram_we_c     = 1'b0;
        ram_a_c      = '0;
        ram_di_c     = '0;
        case (state_q)
            S_INIT: begin
                ram_we_c = 1'b1;
                ram_a_c  = cnt_q;
                ram_di_c = INIT_VAL;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // prio_q = 0 means requester 0 wins a contested cycle
                grant0 = rst_n & bus.req0_valid & (~bus.req1_valid | ~prio_q);
                grant1 = rst_n & bus.req1_valid & (~bus.req0_valid | prio_q);
                if (rst_n && bus.req0_valid && bus.req1_valid) begin
                    prio_d = ~prio_q;
                end
                if (grant0) begin
                    ram_we_c = bus.req0_we;
                    ram_a_c  = bus.req0_addr;
                    ram_di_c = bus.req0_we ? bus.req0_wdata : '0;
                    if (!bus.req0_we) begin
                        rsp0_valid_d = 1'b1;
                        rsp0_rdata_d = bus.ram_spo;
                    end
                end else if (grant1) begin
                    ram_we_c = bus.req1_we;
                    ram_a_c  = bus.req1_addr;
                    ram_di_c = bus.req1_we ? bus.req1_wdata : '0;
                    if (!bus.req1_we) begin
                        rsp1_valid_d = 1'b1;
                        rsp1_rdata_d = bus.ram_spo;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            prio_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prio_q       <= prio_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;
    assign bus.ram_we     = ram_we_c & rst_n;
    assign bus.ram_a      = ram_a_c;
    assign bus.ram_di     = ram_di_c;
    assign bus.init_done  = (state_q == S_RUN);
endmodule

// File: tb/tb_rams_dist_arb.sv
// tb/tb_rams_dist_arb.sv - randomized scoreboard bench for rams_dist_arb with a RAM model
module tb_rams_dist_arb;
    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    rams_dist_arb_if #(.AW(6), .DW(16)) bus();

    rams_dist_arb #(.AW(6), .DW(16), .INIT_VAL(16'h0000)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: starts full of garbage so the clear is observable
    logic [15:0] ram_mem [64];
    bit          filled = 1'b0;
    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= 16'($urandom);
            filled <= 1'b1;
        end else if (bus.ram_we) begin
            ram_mem[bus.ram_a] <= bus.ram_di;
        end
    end
    assign bus.ram_spo = ram_mem[bus.ram_a];

    // Reference model state
    logic [15:0] ref_mem [64];
    bit          m_prio = 1'b0;
    exp_t        q0[$];
    exp_t        q1[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp0_valid) begin
                if (q0.size() == 0) chk("rsp0_unexpected", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("rsp0_rdata", bus.rsp0_rdata, e.data);
                    chk("rsp0_latency", cyc, e.cyc);
                end
            end
            if (bus.rsp1_valid) begin
                if (q1.size() == 0) chk("rsp1_unexpected", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("rsp1_rdata", bus.rsp1_rdata, e.data);
                    chk("rsp1_latency", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic set_idle();
        bus.req0_valid = 0; bus.req0_we = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
        bus.req1_valid = 0; bus.req1_we = 0; bus.req1_addr = 0; bus.req1_wdata = 0;
    endtask

    task automatic apply(input int r, input logic we, input logic [5:0] a, input logic [15:0] d);
        exp_t e;
        if (we) begin
            ref_mem[a] = d;
            chk("grant_wr_ram_we", bus.ram_we, 1);
            chk("grant_wr_ram_a", bus.ram_a, a);
            chk("grant_wr_ram_di", bus.ram_di, d);
        end else begin
            chk("grant_rd_ram_we", bus.ram_we, 0);
            chk("grant_rd_ram_a", bus.ram_a, a);
            e.data = ref_mem[a];
            e.cyc  = cyc + 1;
            if (r == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic do_cycle(input logic v0, input logic we0, input logic [5:0] a0, input logic [15:0] d0,
                            input logic v1, input logic we1, input logic [5:0] a1, input logic [15:0] d1,
                            output logic g0, output logic g1);
        @(posedge clk); #1;
        bus.req0_valid = v0; bus.req0_we = we0; bus.req0_addr = a0; bus.req0_wdata = d0;
        bus.req1_valid = v1; bus.req1_we = we1; bus.req1_addr = a1; bus.req1_wdata = d1;
        #1;
        if (v0 && v1) begin
            g0 = !m_prio;
            g1 = m_prio;
            m_prio = !m_prio;
        end else begin
            g0 = v0;
            g1 = v1;
        end
        chk("req0_ready", bus.req0_ready, g0);
        chk("req1_ready", bus.req1_ready, g1);
        if (g0) apply(0, we0, a0, d0);
        else if (g1) apply(1, we1, a1, d1);
        else chk("idle_ram_we", bus.ram_we, 0);
    endtask

    // Caller releases rst_n at posedge+1; checks n consecutive clear writes
    task automatic run_init(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #2; end else #1;
            chk("init_ram_we", bus.ram_we, 1);
            chk("init_ram_a", bus.ram_a, i);
            chk("init_ram_di", bus.ram_di, 0);
            chk("init_done_low", bus.init_done, 0);
            chk("init_ready0", bus.req0_ready, 0);
        end
        if (n == 64) begin
            @(posedge clk); #1;
            set_idle();
            #1;
            chk("init_done_high", bus.init_done, 1);
            chk("run_idle_ram_we", bus.ram_we, 0);
            for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0000;
            m_prio = 1'b0;
        end
    endtask

    initial begin
        logic g0, g1;
        logic pv0, pwe0, pv1, pwe1;
        logic [5:0] pa0, pa1;
        logic [15:0] pd0, pd1;
        set_idle();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_init_done", bus.init_done, 0);
        chk("reset_rsp0_valid", bus.rsp0_valid, 0);
        chk("reset_rsp0_rdata", bus.rsp0_rdata, 0);
        chk("reset_ram_we", bus.ram_we, 0);

        // First clear aborted at cycle 30, then a full clear
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.req0_valid = 1'b1;
        run_init(30);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ram_we_0", bus.ram_we, 0);
        @(posedge clk); #2;
        chk("abort_ram_we_1", bus.ram_we, 0);
        chk("abort_init_done", bus.init_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_init(64);

        do_cycle(1, 1, 6'h05, 16'hA5A5, 0, 0, 0, 0, g0, g1);
        do_cycle(1, 0, 6'h05, 16'h0000, 0, 0, 0, 0, g0, g1);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1, 0, 6'h01, 0, 1, 0, 6'h02, 0, g0, g1);
            chk("contested_order", {31'd0, g1}, i % 2);
        end
        do_cycle(0, 0, 0, 0, 1, 1, 6'h3F, 16'h1234, g0, g1);
        do_cycle(1, 0, 6'h3F, 0, 0, 0, 0, 0, g0, g1);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        pv0 = 0; pv1 = 0; pwe0 = 0; pwe1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
        for (int k = 0; k < 2; k++) begin
            repeat (400) begin
                if (!pv0) begin
                    pv0  = ($urandom_range(0, 9) < 6);
                    pwe0 = 1'($urandom_range(0, 1));
                    pa0  = $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
                    pd0  = 16'($urandom);
                end
                if (!pv1) begin
                    pv1  = ($urandom_range(0, 9) < 6);
                    pwe1 = 1'($urandom_range(0, 1));
                    pa1  = $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
                    pd1  = 16'($urandom);
                end
                do_cycle(pv0, pwe0, pa0, pd0, pv1, pwe1, pa1, pd1, g0, g1);
                if (g0) pv0 = 0;
                if (g1) pv1 = 0;
            end
            if (k == 0) begin
                // Make rsp0_rdata nonzero, then reset on a cycle presenting a read
                do_cycle(0, 0, 0, 0, 1, 1, 6'h2A, 16'hBEEF, g0, g1);
                do_cycle(1, 0, 6'h2A, 0, 0, 0, 0, 0, g0, g1);
                @(posedge clk); #1;
                chk("pre_reset_rsp0_rdata", bus.rsp0_rdata, 16'hBEEF);
                rst_n = 1'b0;
                bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 6'h2A;
                #1;
                chk("rst_grant_ready0", bus.req0_ready, 0);
                chk("rst_grant_ram_we", bus.ram_we, 0);
                @(posedge clk); #2;
                chk("rst_rsp0_valid", bus.rsp0_valid, 0);
                chk("rst_rsp0_rdata", bus.rsp0_rdata, 0);
                chk("rst_rsp1_rdata", bus.rsp1_rdata, 0);
                chk("rst_init_done", bus.init_done, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                run_init(64);
                pv0 = 0; pv1 = 0;
            end
        end

        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        repeat (3) @(posedge clk);
        #2;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
